// File: rtl/voice_mixer_tdm.sv
// voice_mixer_tdm: time-multiplexed N-channel audio mixer.
// A sample_req pulse snapshots every voice sample, every per-channel gain and the
// master volume. One channel per clock then goes through a single shared multiplier
// into a wide accumulator. The sum is scaled by the master volume, saturated to
// SAMPLE_W, and presented with a one-cycle valid pulse.
//
// Ports:
//   clk          system clock
//   reset_n      asynchronous active-low reset
//   sample_req   single-cycle request at the audio sample rate
//   ch_samples   N_CH packed signed samples, ch0 in the LSBs
//   ch_gain      N_CH packed unsigned gains, ch0 in the LSBs (g scales by g/2^GAIN_W)
//   master_vol   unsigned master volume (v scales by v/2^VOL_W)
//   peak_clr     clears peak_level (present only with MIXER_PEAK_EN)
//   mixed_sample signed mixed output, held between updates
//   mixed_valid  one-cycle pulse when mixed_sample updates
//   busy         high from capture through the output cycle
//   clip         current mixed_sample was saturated
//   overrun      sticky: sample_req arrived while busy
//   peak_level   max |mixed_sample| since reset/clear (tied to 0 without MIXER_PEAK_EN)
//
// Optional feature macro: MIXER_PEAK_EN enables peak tracking and the peak_clr input.
module voice_mixer_tdm #(
    parameter int unsigned N_CH     = 8,
    parameter int unsigned SAMPLE_W = 24,
    parameter int unsigned GAIN_W   = 8,
    parameter int unsigned VOL_W    = 8
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic                       sample_req,
    input  logic [N_CH*SAMPLE_W-1:0]   ch_samples,
    input  logic [N_CH*GAIN_W-1:0]     ch_gain,
    input  logic [VOL_W-1:0]           master_vol,
`ifdef MIXER_PEAK_EN
    input  logic                       peak_clr,
`endif
    output logic [SAMPLE_W-1:0]        mixed_sample,
    output logic                       mixed_valid,
    output logic                       busy,
    output logic                       clip,
    output logic                       overrun,
    output logic [SAMPLE_W-2:0]        peak_level
);

    localparam int unsigned CL   = $clog2(N_CH);
    localparam int unsigned PW   = SAMPLE_W + GAIN_W + 1;   // signed x unsigned product
    localparam int unsigned AW   = PW + CL;                 // accumulator, cannot overflow
    localparam int unsigned SH_W = AW - GAIN_W;             // accumulator after gain shift
    localparam int unsigned MW   = SH_W + VOL_W + 1;        // volume product
    localparam int unsigned TW   = SH_W + 1;                // volume product after shift

    localparam logic [SAMPLE_W-1:0] SAT_MAX = {1'b0, {(SAMPLE_W-1){1'b1}}};
    localparam logic [SAMPLE_W-1:0] SAT_MIN = {1'b1, {(SAMPLE_W-1){1'b0}}};

    typedef enum logic [1:0] {StIdle, StAccum, StScale, StOut} state_e;

    state_e                     state_q, state_d;
    logic [N_CH*SAMPLE_W-1:0]   snap_samples_q, snap_samples_d;
    logic [N_CH*GAIN_W-1:0]     snap_gain_q, snap_gain_d;
    logic [VOL_W-1:0]           snap_vol_q, snap_vol_d;
    logic signed [AW-1:0]       acc_q, acc_d;
    logic [CL-1:0]              idx_q, idx_d;
    logic signed [TW-1:0]       t_q, t_d;
    logic [SAMPLE_W-1:0]        mixed_q, mixed_d;
    logic                       valid_q, valid_d;
    logic                       clip_q, clip_d;
    logic                       overrun_q, overrun_d;

    // Shared multiply-accumulate datapath
    logic [SAMPLE_W-1:0]        cur_sample;
    logic [GAIN_W-1:0]          cur_gain;
    logic signed [PW-1:0]       s_ext, g_ext, prod;
    logic signed [MW-1:0]       a_ext, v_ext, vprod;
    logic signed [TW-1:0]       scaled;
    logic [TW-SAMPLE_W:0]       hi_bits;
    logic                       ovf;
    logic [SAMPLE_W-1:0]        sat_val;

    assign cur_sample = snap_samples_q[idx_q*SAMPLE_W +: SAMPLE_W];
    assign cur_gain   = snap_gain_q[idx_q*GAIN_W +: GAIN_W];
    assign s_ext      = {{(GAIN_W+1){cur_sample[SAMPLE_W-1]}}, cur_sample};
    assign g_ext      = {{(SAMPLE_W+1){1'b0}}, cur_gain};
    assign prod       = s_ext * g_ext;

    // Dropping the low bits of a two's-complement value is a floor shift.
    assign a_ext  = {{(VOL_W+1){acc_q[AW-1]}}, acc_q[AW-1:GAIN_W]};
    assign v_ext  = {{(SH_W+1){1'b0}}, snap_vol_q};
    assign vprod  = a_ext * v_ext;
    assign scaled = vprod[MW-1:VOL_W];

    // Value fits SAMPLE_W only if all bits from the output sign bit upward agree.
    assign hi_bits = t_q[TW-1:SAMPLE_W-1];
    assign ovf     = ~((&hi_bits) | ~(|hi_bits));
    assign sat_val = ovf ? (t_q[TW-1] ? SAT_MIN : SAT_MAX) : t_q[SAMPLE_W-1:0];

    always_comb begin
        state_d        = state_q;
        snap_samples_d = snap_samples_q;
        snap_gain_d    = snap_gain_q;
        snap_vol_d     = snap_vol_q;
        acc_d          = acc_q;
        idx_d          = idx_q;
        t_d            = t_q;
        mixed_d        = mixed_q;
        valid_d        = 1'b0;
        clip_d         = clip_q;
        overrun_d      = overrun_q;

        if (sample_req && (state_q != StIdle)) begin
            overrun_d = 1'b1;
        end

        unique case (state_q)
            StIdle: begin
                if (sample_req) begin
                    snap_samples_d = ch_samples;
                    snap_gain_d    = ch_gain;
                    snap_vol_d     = master_vol;
                    acc_d          = '0;
                    idx_d          = '0;
                    state_d        = StAccum;
                end
            end
            StAccum: begin
                acc_d = acc_q + {{CL{prod[PW-1]}}, prod};
                idx_d = idx_q + 1'b1;
                if (idx_q == CL'(N_CH - 1)) begin
                    state_d = StScale;
                end
            end
            StScale: begin
                t_d     = scaled;
                state_d = StOut;
            end
            StOut: begin
                mixed_d = sat_val;
                clip_d  = ovf;
                valid_d = 1'b1;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q        <= StIdle;
            snap_samples_q <= '0;
            snap_gain_q    <= '0;
            snap_vol_q     <= '0;
            acc_q          <= '0;
            idx_q          <= '0;
            t_q            <= '0;
            mixed_q        <= '0;
            valid_q        <= 1'b0;
            clip_q         <= 1'b0;
            overrun_q      <= 1'b0;
        end else begin
            state_q        <= state_d;
            snap_samples_q <= snap_samples_d;
            snap_gain_q    <= snap_gain_d;
            snap_vol_q     <= snap_vol_d;
            acc_q          <= acc_d;
            idx_q          <= idx_d;
            t_q            <= t_d;
            mixed_q        <= mixed_d;
            valid_q        <= valid_d;
            clip_q         <= clip_d;
            overrun_q      <= overrun_d;
        end
    end

    assign mixed_sample = mixed_q;
    assign mixed_valid  = valid_q;
    assign clip         = clip_q;
    assign overrun      = overrun_q;
    assign busy         = (state_q != StIdle);

`ifdef MIXER_PEAK_EN
    logic [SAMPLE_W-2:0] peak_q, peak_d, mag;

    // |-2^(SAMPLE_W-1)| does not fit, so it saturates to all ones.
    always_comb begin
        mag = sat_val[SAMPLE_W-2:0];
        if (sat_val[SAMPLE_W-1]) begin
            mag = (sat_val == SAT_MIN) ? '1 : (~sat_val[SAMPLE_W-2:0]) + 1'b1;
        end
    end

    always_comb begin
        peak_d = peak_q;
        if (peak_clr) begin
            peak_d = (state_q == StOut) ? mag : '0;
        end else if ((state_q == StOut) && (mag > peak_q)) begin
            peak_d = mag;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            peak_q <= '0;
        end else begin
            peak_q <= peak_d;
        end
    end

    assign peak_level = peak_q;
`else
    assign peak_level = '0;
`endif

endmodule
